// File: rtl/quick_spi_pkg.sv
// Shared SPI definitions: bus mode constants and the transfer FSM state type.
package quick_spi_pkg;

  // Mode 0: SCK idles low, data sampled on the rising edge.
  localparam bit SPI_CPOL = 1'b0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_TRANSFER = 1'b1
  } spi_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/quick_spi_sck_gen.sv
// SCK generator: free-running divider that runs only while enabled and
// flags the clk edges on which SCK rises and falls.
module quick_spi_sck_gen
  import quick_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [CLK_DIV-1:0] HALF_LAST   = CLK_DIV'((1 << (CLK_DIV - 1)) - 1);
  localparam logic [CLK_DIV-1:0] PERIOD_LAST = '1;

  logic [CLK_DIV-1:0] ctr;

  // Ticks mark the edge on which ctr leaves H-1 (SCK rises) or P-1 (SCK falls).
  assign rise_tick = en && (ctr == HALF_LAST);
  assign fall_tick = en && (ctr == PERIOD_LAST);

  // sck always equals the counter MSB while enabled, held idle otherwise.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      ctr <= '0;
      sck <= SPI_CPOL;
    end else begin
      ctr <= ctr + 1'b1;
      if (rise_tick) begin
        sck <= ~SPI_CPOL;
      end else if (fall_tick) begin
        sck <= SPI_CPOL;
      end
    end
  end

endmodule

// File: rtl/quick_spi.sv
// Single-transfer SPI master, mode 0, MSB first, full duplex.
// A start pulse while idle shifts DATA_WIDTH bits out on mosi and in from miso.
module quick_spi
  import quick_spi_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sck,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  new_data
);

  localparam int              CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  spi_state_e            state;
  spi_state_e            state_next;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_in;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  rx_bit;
  logic                  rise_tick;
  logic                  fall_tick;
  logic                  accept;
  logic                  done;

  quick_spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (busy),
    .sck      (sck),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  assign shift_in = {shift[DATA_WIDTH-2:0], rx_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start) state_next = ST_TRANSFER;
      ST_TRANSFER: if (fall_tick && (bit_cnt == LAST_BIT)) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    accept = 1'b0;
    done   = 1'b0;
    case (state)
      ST_IDLE:     accept = start;
      ST_TRANSFER: begin
        busy = 1'b1;
        done = fall_tick && (bit_cnt == LAST_BIT);
      end
      default:     ;
    endcase
  end

  // Received bits enter at the LSB and never reach the mosi tap before the
  // final boundary, so an undriven miso cannot leak onto mosi.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift    <= '0;
      bit_cnt  <= '0;
      rx_bit   <= 1'b0;
      mosi     <= 1'b0;
      data_out <= '0;
      new_data <= 1'b0;
    end else begin
      new_data <= done;
      if (accept) begin
        shift   <= data_in;
        bit_cnt <= '0;
        mosi    <= data_in[DATA_WIDTH-1];
      end else if (busy) begin
        if (rise_tick) begin
          rx_bit <= miso;
        end
        if (fall_tick) begin
          shift   <= shift_in;
          bit_cnt <= bit_cnt + 1'b1;
          mosi    <= done ? 1'b0 : shift[DATA_WIDTH-2];
        end
        if (done) begin
          data_out <= shift_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_quick_spi.sv
// Bench for quick_spi: two instances (CLK_DIV=2 and CLK_DIV=1) checked against
// a byte-level protocol model (bit order, timing budget, received byte).
module tb_quick_spi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  bit         sel = 1'b0;
  bit         loop_mode = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] slave_sh = 8'h00;

  logic       start0, miso0, mosi0, sck0, busy0, nd0;
  logic [7:0] dout0;
  logic       start1, miso1, mosi1, sck1, busy1, nd1;
  logic [7:0] dout1;

  logic       o_sck, o_mosi, o_busy, o_nd;
  logic [7:0] o_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign miso0  = loop_mode ? mosi0 : slave_sh[7];
  assign miso1  = mosi1;

  assign o_sck  = sel ? sck1  : sck0;
  assign o_mosi = sel ? mosi1 : mosi0;
  assign o_busy = sel ? busy1 : busy0;
  assign o_nd   = sel ? nd1   : nd0;
  assign o_dout = sel ? dout1 : dout0;

  quick_spi #(.CLK_DIV(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .miso(miso0), .mosi(mosi0), .sck(sck0),
    .start(start0), .data_in(data_in), .data_out(dout0),
    .busy(busy0), .new_data(nd0)
  );

  quick_spi #(.CLK_DIV(1), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .miso(miso1), .mosi(mosi1), .sck(sck1),
    .start(start1), .data_in(data_in), .data_out(dout1),
    .busy(busy1), .new_data(nd1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer on the selected instance; called at a negedge while idle
  // (or at the idle gap of a held start). Returns at the first idle sample,
  // or one cycle later when start is not held.
  task automatic xfer(input logic [7:0] din, input logic [7:0] sbyte,
                      input bit lp, input bit hold, input bit mid);
    int         p = sel ? 2 : 4;
    int         h = p / 2;
    logic [7:0] exp_rx = (sel || lp) ? din : sbyte;
    int         cyc = 0;
    int         rises = 0;
    int         run = 0;
    int         nd = 0;
    logic       prev = 1'b0;
    logic [7:0] bits = 8'h00;
    bit         ended = 1'b0;
    loop_mode = lp;
    slave_sh  = sbyte;
    data_in   = din;
    start     = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    data_in = ~din;
    chk("busy_up", o_busy, 1);
    chk("nd_low", o_nd, 0);
    for (int g = 0; g < 2000; g++) begin
      if (o_nd === 1'b1) nd++;
      if (o_sck && !prev) begin
        bits  = {bits[6:0], o_mosi};
        rises++;
        run   = 0;
      end
      if (o_sck) run++;
      if (!o_sck && prev) begin
        chk("sck_hi_len", run, h);
        slave_sh = slave_sh << 1;
      end
      prev = o_sck;
      if (!o_busy) begin
        ended = 1'b1;
        break;
      end
      cyc++;
      if (mid && cyc == 10) start = 1'b1;
      if (mid && cyc == 11) start = 1'b0;
      @(negedge clk);
    end
    chk("ended", ended, 1);
    chk("busy_len", cyc, 8 * p);
    chk("sck_rises", rises, 8);
    chk("mosi_bits", bits, din);
    chk("nd_count", nd, 1);
    chk("data_out", o_dout, exp_rx);
    chk("idle_sck", o_sck, 0);
    chk("idle_mosi", o_mosi, 0);
    if (!hold) begin
      @(negedge clk);
      chk("nd_pulse", o_nd, 0);
      chk("no_queue", o_busy, 0);
      chk("dout_hold", o_dout, exp_rx);
    end
  endtask

  initial begin
    int nd_seen;
    logic [7:0] d;
    logic [7:0] s;

    // Reset held with start asserted.
    start   = 1'b1;
    data_in = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_sck", sck0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_nd", nd0, 0);
    chk("rst_dout", dout0, 8'h00);
    chk("rst_busy1", busy1, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);

    sel = 1'b0;
    xfer(8'h6C, 8'h00, 1'b1, 1'b0, 1'b0);
    xfer(8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0);

    // Held start: back-to-back with one idle cycle, then a stray pulse mid-transfer.
    xfer(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
    xfer(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);

    // Make data_out nonzero, then abort a transfer with reset.
    xfer(8'hC3, 8'h00, 1'b1, 1'b0, 1'b0);
    loop_mode = 1'b1;
    data_in   = 8'h5A;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_sck", sck0, 0);
    chk("abort_mosi", mosi0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_nd", nd0, 0);
    chk("abort_dout", dout0, 8'h00);
    rst = 1'b0;
    nd_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (nd0 !== 1'b0 || busy0 !== 1'b0) nd_seen++;
    end
    chk("abort_quiet", nd_seen, 0);
    xfer(8'h96, 8'h00, 1'b1, 1'b0, 1'b0);

    sel = 1'b1;
    xfer(8'h81, 8'h00, 1'b1, 1'b0, 1'b0);
    sel = 1'b0;

    for (int i = 0; i < 24; i++) begin
      sel = ($urandom_range(0, 3) == 0);
      d   = 8'($urandom);
      s   = 8'($urandom);
      xfer(d, s, ($urandom_range(0, 1) == 1), 1'b0, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
